// File: rtl/memio_arbiter_if.sv
// memio bus bundle: CPU and DMA requester ports, shared memory port and owner.
// slave = arbiter side, master = requesters + memory side.
interface memio_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner
  );
endinterface

// File: rtl/memio_arbiter.sv
// Two-requester memio arbiter: CPU has fixed priority, DMA is forced through
// after STARVE_LIM consecutive CPU wins. Each access runs IDLE -> ISSUE ->
// WAIT (MEM_LAT-1 cycles) -> DONE; at most one access is ever in flight.
// Every output comes straight from a flop.
module memio_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic           clk,
  input  logic           rst,
  memio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  localparam logic [1:0] OWN_NONE  = 2'b00;
  localparam logic [1:0] OWN_CPU   = 2'b01;
  localparam logic [1:0] OWN_DMA   = 2'b10;
  localparam logic [3:0] SLIM      = 4'(STARVE_LIM);
  // WAIT counts down to zero; loaded with MEM_LAT-2 so it spans MEM_LAT-1 cycles
  localparam logic [2:0] WAIT_INIT = 3'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  state_t        state, state_d;
  logic [3:0]    starve, starve_d;
  logic [2:0]    wcnt, wcnt_d;
  logic [1:0]    owner_q, owner_d;
  req_t          cpu_fld, dma_fld, win_q, win_d;
  logic          en_q, en_d;
  logic          we_q, we_d;
  logic          cack_q, cack_d;
  logic          dack_q, dack_d;
  logic [DW-1:0] crd_q, crd_d;
  logic [DW-1:0] drd_q, drd_d;
  logic          pick_dma;
  logic          cap;

  assign cpu_fld = {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata};
  assign dma_fld = {bus.dma_we, bus.dma_addr, bus.dma_wdata};

  // next-state, arbitration and next values of every registered output
  always_comb begin
    state_d  = state;
    starve_d = starve;
    wcnt_d   = wcnt;
    owner_d  = owner_q;
    win_d    = win_q;
    en_d     = 1'b0;
    we_d     = 1'b0;
    cack_d   = 1'b0;
    dack_d   = 1'b0;
    crd_d    = crd_q;
    drd_d    = drd_q;
    pick_dma = 1'b0;
    cap      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.dma_req) starve_d = '0;
        if (bus.cpu_req || bus.dma_req) begin
          pick_dma = bus.dma_req && (!bus.cpu_req || (starve == SLIM));
          if (pick_dma) begin
            owner_d  = OWN_DMA;
            win_d    = dma_fld;
            starve_d = '0;
          end else begin
            owner_d = OWN_CPU;
            win_d   = cpu_fld;
            // count CPU wins that pushed a pending DMA aside
            if (bus.dma_req && (starve != SLIM)) starve_d = starve + 4'd1;
          end
          en_d    = 1'b1;
          we_d    = win_d.we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (MEM_LAT == 1) begin
          cap = 1'b1;
        end else begin
          wcnt_d  = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == 3'd0) cap = 1'b1;
        else              wcnt_d = wcnt - 3'd1;
      end
      DONE: begin
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // read data is valid at this edge: capture it and raise the winner's ack
    if (cap) begin
      state_d = DONE;
      if (owner_q == OWN_DMA) begin
        dack_d = 1'b1;
        drd_d  = bus.mem_rdata;
      end else begin
        cack_d = 1'b1;
        crd_d  = bus.mem_rdata;
      end
    end
  end

  // state and output registers, synchronous reset aborts any access
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      starve  <= '0;
      wcnt    <= '0;
      owner_q <= OWN_NONE;
      win_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      cack_q  <= 1'b0;
      dack_q  <= 1'b0;
      crd_q   <= '0;
      drd_q   <= '0;
    end else begin
      state   <= state_d;
      starve  <= starve_d;
      wcnt    <= wcnt_d;
      owner_q <= owner_d;
      win_q   <= win_d;
      en_q    <= en_d;
      we_q    <= we_d;
      cack_q  <= cack_d;
      dack_q  <= dack_d;
      crd_q   <= crd_d;
      drd_q   <= drd_d;
    end
  end

  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = win_q.addr;
  assign bus.mem_wdata = win_q.wdata;
  assign bus.cpu_ack   = cack_q;
  assign bus.cpu_rdata = crd_q;
  assign bus.dma_ack   = dack_q;
  assign bus.dma_rdata = drd_q;
  assign bus.owner     = owner_q;

endmodule
